// File: rtl/mpc_qp_admm_z_update.sv
// -----------------------------------------------------------------------------
// mpc_qp_admm_z_update
//
// ADMM slack/dual update stage. A start pulse launches one sweep over all
// AddressRange entries. Each entry takes two cycles: RD issues the reads and
// WB consumes the data and writes back:
//    v    = sat(x + u)
//    z    = clamp(v, lo, hi)   (hi wins when lo > hi)
//    u    = sat(v - z)
// Max-norm primal/dual residuals are accumulated over the sweep.
//
// Optional feature macro: MPC_ZUPD_RESID_EN
//    defined   : r_prim / r_dual residual datapath is built
//    undefined : r_prim / r_dual are tied to 0 and zk_q0 is not used
//
// Ports
//    clk, reset (async, active-low)
//    start, busy, done              : sweep handshake
//    lo, hi                         : clamp bounds, stable while busy
//    x_address0/x_ce0/x_q0          : relaxed primal RAM (read only)
//    zk_address0/ce0/we0/d0/q0      : slack RAM (read then write back)
//    u_address0/ce0/we0/d0/q0       : scaled dual RAM (read then write back)
//    r_prim, r_dual                 : residuals, final in the done cycle
// -----------------------------------------------------------------------------
module mpc_qp_admm_z_update #(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 5,
   parameter int AddressRange = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic [DataWidth-1:0]    lo,
   input  logic [DataWidth-1:0]    hi,
   output logic [AddressWidth-1:0] x_address0,
   output logic                    x_ce0,
   input  logic [DataWidth-1:0]    x_q0,
   output logic [AddressWidth-1:0] zk_address0,
   output logic                    zk_ce0,
   output logic                    zk_we0,
   output logic [DataWidth-1:0]    zk_d0,
   input  logic [DataWidth-1:0]    zk_q0,
   output logic [AddressWidth-1:0] u_address0,
   output logic                    u_ce0,
   output logic                    u_we0,
   output logic [DataWidth-1:0]    u_d0,
   input  logic [DataWidth-1:0]    u_q0,
   output logic [DataWidth-1:0]    r_prim,
   output logic [DataWidth-1:0]    r_dual
);

   localparam logic signed [DataWidth-1:0] SMAX = {1'b0, {(DataWidth-1){1'b1}}};
   localparam logic signed [DataWidth-1:0] SMIN = {1'b1, {(DataWidth-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WB, S_DONE} state_t;

   state_t                  state_reg;
   state_t                  state_next;
   logic [AddressWidth-1:0] idx_reg;
   logic                    last_entry;
   logic                    sweep_start;

   // a + b (or a - b) evaluated one bit wider, then clipped to the signed range
   function automatic logic signed [DataWidth-1:0] sat_sum(
      input logic signed [DataWidth-1:0] a,
      input logic signed [DataWidth-1:0] b,
      input logic                        negate_b
   );
      logic signed [DataWidth:0] s;
      if (negate_b)
         s = {a[DataWidth-1], a} - {b[DataWidth-1], b};
      else
         s = {a[DataWidth-1], a} + {b[DataWidth-1], b};
      if (s[DataWidth] != s[DataWidth-1])
         sat_sum = s[DataWidth] ? SMIN : SMAX;
      else
         sat_sum = s[DataWidth-1:0];
   endfunction

   assign last_entry  = (idx_reg == AddressWidth'(AddressRange - 1));
   assign sweep_start = (state_reg == S_IDLE) && start;

   // ---------------------------------------------------------------- datapath
   logic signed [DataWidth-1:0] x_s;
   logic signed [DataWidth-1:0] u_s;
   logic signed [DataWidth-1:0] lo_s;
   logic signed [DataWidth-1:0] hi_s;
   logic signed [DataWidth-1:0] v_sum;
   logic signed [DataWidth-1:0] z_new;
   logic signed [DataWidth-1:0] u_new;

   assign x_s  = $signed(x_q0);
   assign u_s  = $signed(u_q0);
   assign lo_s = $signed(lo);
   assign hi_s = $signed(hi);

   always_comb begin
      v_sum = sat_sum(x_s, u_s, 1'b0);
      // an empty interval collapses to hi
      if (lo_s > hi_s)
         z_new = hi_s;
      else if (v_sum < lo_s)
         z_new = lo_s;
      else if (v_sum > hi_s)
         z_new = hi_s;
      else
         z_new = v_sum;
      u_new = sat_sum(v_sum, z_new, 1'b1);
   end

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = S_RD;
         S_RD:    state_next = S_WB;
         S_WB:    state_next = last_entry ? S_DONE : S_RD;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // outputs decode straight from state so an asynchronous reset clears them at once
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      x_ce0       = 1'b0;
      zk_ce0      = 1'b0;
      u_ce0       = 1'b0;
      zk_we0      = 1'b0;
      u_we0       = 1'b0;
      x_address0  = '0;
      zk_address0 = '0;
      u_address0  = '0;
      zk_d0       = '0;
      u_d0        = '0;
      case (state_reg)
         S_RD: begin
            busy        = 1'b1;
            x_ce0       = 1'b1;
            zk_ce0      = 1'b1;
            u_ce0       = 1'b1;
            x_address0  = idx_reg;
            zk_address0 = idx_reg;
            u_address0  = idx_reg;
         end
         S_WB: begin
            busy        = 1'b1;
            zk_ce0      = 1'b1;
            u_ce0       = 1'b1;
            zk_we0      = 1'b1;
            u_we0       = 1'b1;
            zk_address0 = idx_reg;
            u_address0  = idx_reg;
            zk_d0       = z_new;
            u_d0        = u_new;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // entry index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         idx_reg <= '0;
      else if (sweep_start)
         idx_reg <= '0;
      else if (state_reg == S_WB && !last_entry)
         idx_reg <= idx_reg + 1'b1;
   end

   // -------------------------------------------------------------- residuals
`ifdef MPC_ZUPD_RESID_EN
   logic signed [DataWidth-1:0] r_prim_reg;
   logic signed [DataWidth-1:0] r_dual_reg;
   logic signed [DataWidth-1:0] prim_abs;
   logic signed [DataWidth-1:0] dual_abs;

   // the most negative value has no positive twin, so it clips to SMAX
   function automatic logic signed [DataWidth-1:0] abs_sat(
      input logic signed [DataWidth-1:0] a
   );
      if (a == SMIN)
         abs_sat = SMAX;
      else if (a[DataWidth-1])
         abs_sat = -a;
      else
         abs_sat = a;
   endfunction

   assign prim_abs = abs_sat(sat_sum(x_s, z_new, 1'b1));
   assign dual_abs = abs_sat(sat_sum(z_new, $signed(zk_q0), 1'b1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prim_reg <= '0;
         r_dual_reg <= '0;
      end else if (sweep_start) begin
         r_prim_reg <= '0;
         r_dual_reg <= '0;
      end else if (state_reg == S_WB) begin
         if (prim_abs > r_prim_reg) r_prim_reg <= prim_abs;
         if (dual_abs > r_dual_reg) r_dual_reg <= dual_abs;
      end
   end

   assign r_prim = r_prim_reg;
   assign r_dual = r_dual_reg;
`else
   logic unused_zk_q0;

   assign unused_zk_q0 = ^zk_q0;
   assign r_prim       = '0;
   assign r_dual       = '0;
`endif

endmodule

// File: tb/tb_mpc_qp_admm_z_update.sv
module tb_mpc_qp_admm_z_update;

   localparam int N = 24;

   logic        clk;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] lo;
   logic [31:0] hi;
   logic [4:0]  x_address0;
   logic        x_ce0;
   logic [31:0] x_q0;
   logic [4:0]  zk_address0;
   logic        zk_ce0;
   logic        zk_we0;
   logic [31:0] zk_d0;
   logic [31:0] zk_q0;
   logic [4:0]  u_address0;
   logic        u_ce0;
   logic        u_we0;
   logic [31:0] u_d0;
   logic [31:0] u_q0;
   logic [31:0] r_prim;
   logic [31:0] r_dual;

   mpc_qp_admm_z_update #(
      .DataWidth   (32),
      .AddressWidth(5),
      .AddressRange(N)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .lo         (lo),
      .hi         (hi),
      .x_address0 (x_address0),
      .x_ce0      (x_ce0),
      .x_q0       (x_q0),
      .zk_address0(zk_address0),
      .zk_ce0     (zk_ce0),
      .zk_we0     (zk_we0),
      .zk_d0      (zk_d0),
      .zk_q0      (zk_q0),
      .u_address0 (u_address0),
      .u_ce0      (u_ce0),
      .u_we0      (u_we0),
      .u_d0       (u_d0),
      .u_q0       (u_q0),
      .r_prim     (r_prim),
      .r_dual     (r_dual)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------- RAM models
   logic [31:0] x_mem  [N];
   logic [31:0] zk_mem [N];
   logic [31:0] u_mem  [N];
   logic [31:0] x_init [N];
   logic [31:0] zk_init[N];
   logic [31:0] u_init [N];
   int          load_seq  = 0;
   int          load_seen = 0;

   // single-port, read-first, 1-cycle latency; preload copies happen here too
   always @(posedge clk) begin
      if (load_seq != load_seen) begin
         load_seen <= load_seq;
         for (int k = 0; k < N; k++) begin
            x_mem[k]  <= x_init[k];
            zk_mem[k] <= zk_init[k];
            u_mem[k]  <= u_init[k];
         end
      end else begin
         if (x_ce0) x_q0 <= x_mem[x_address0];
         if (zk_ce0) begin
            zk_q0 <= zk_mem[zk_address0];
            if (zk_we0) zk_mem[zk_address0] <= zk_d0;
         end
         if (u_ce0) begin
            u_q0 <= u_mem[u_address0];
            if (u_we0) u_mem[u_address0] <= u_d0;
         end
      end
   end

   // ------------------------------------------------------------ checking
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   function automatic logic [31:0] resid(input logic [31:0] e);
`ifdef MPC_ZUPD_RESID_EN
      return e;
`else
      return (e & 32'h0);
`endif
   endfunction

   // called at a negedge while the DUT RAM ports are idle
   task automatic load_mem();
      load_seq++;
   endtask

   // starts a sweep and returns at the negedge of the done cycle
   task automatic run_sweep(output int done_cyc, output int proto_err);
      proto_err = 0;
      done_cyc  = -1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (!busy) proto_err++;
         if (done) begin
            done_cyc = c;
            break;
         end
         if (c % 2 == 1) begin
            if (!(x_ce0 && zk_ce0 && u_ce0 && !zk_we0 && !u_we0 &&
                  int'(x_address0) == (c - 1) / 2 && int'(zk_address0) == (c - 1) / 2 &&
                  int'(u_address0) == (c - 1) / 2))
               proto_err++;
         end else begin
            if (!(!x_ce0 && zk_ce0 && u_ce0 && zk_we0 && u_we0 &&
                  int'(zk_address0) == (c - 2) / 2 && int'(u_address0) == (c - 2) / 2))
               proto_err++;
         end
      end
   endtask

   task automatic check_idle_outputs(input string name);
      logic [31:0] ctl;
      ctl = {24'h0, busy, done, x_ce0, zk_ce0, zk_we0, u_ce0, u_we0, 1'b0};
      check({name, "_ctl"}, ctl, 32'h0);
      check({name, "_addr"}, {17'h0, x_address0, zk_address0, u_address0}, 32'h0);
      check({name, "_d0"}, zk_d0 | u_d0, 32'h0);
      check({name, "_resid"}, r_prim | r_dual, 32'h0);
   endtask

   typedef struct {
      logic [31:0] x, u, zk, lo, hi;
      logic [31:0] ez, eu, erp, erd;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int dc;
      int pe;
      logic [31:0] ez;
      logic [31:0] eu;

      //             x             u             zk            lo            hi            z             u_next        r_prim        r_dual
      vecs[0] = '{32'h00010000, 32'h00000000, 32'h00000000, 32'hFFFF0000, 32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000};
      vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h7FFFFFFF};
      vecs[2] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00020000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h00010000};
      vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000, 32'h7FFFFFFF};
      vecs[4] = '{32'hFFFE0000, 32'h00004000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'hFFFF0000, 32'hFFFF4000, 32'h00010000, 32'h00020000};
      vecs[5] = '{32'h00003000, 32'h00001000, 32'h00002000, 32'h00000000, 32'h00010000, 32'h00004000, 32'h00000000, 32'h00001000, 32'h00002000};
      vecs[6] = '{32'h00001000, 32'h00000000, 32'h00005000, 32'h00005000, 32'h00005000, 32'h00005000, 32'hFFFFC000, 32'h00004000, 32'h00000000};

      reset = 1'b0;
      start = 1'b0;
      lo    = 32'h0;
      hi    = 32'h0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_state");
      reset = 1'b1;
      @(negedge clk);

      // table vectors, each sweep started one cycle after the previous done
      for (int v = 0; v < 7; v++) begin
         for (int k = 0; k < N; k++) begin
            x_init[k]  = vecs[v].x;
            u_init[k]  = vecs[v].u;
            zk_init[k] = vecs[v].zk;
         end
         lo = vecs[v].lo;
         hi = vecs[v].hi;
         load_mem();
         run_sweep(dc, pe);
         check($sformatf("v%0d_done_cycle", v), 32'(dc), 32'd49);
         check($sformatf("v%0d_protocol_errs", v), 32'(pe), 32'd0);
         check($sformatf("v%0d_r_prim", v), r_prim, resid(vecs[v].erp));
         check($sformatf("v%0d_r_dual", v), r_dual, resid(vecs[v].erd));
         for (int k = 0; k < N; k++) begin
            check($sformatf("v%0d_zk[%0d]", v, k), zk_mem[k], vecs[v].ez);
            check($sformatf("v%0d_u[%0d]", v, k), u_mem[k], vecs[v].eu);
         end
         check($sformatf("v%0d_x_untouched", v), x_mem[N-1], vecs[v].x);
      end

      // inside bounds: z stays equal to x, u stays zero
      for (int k = 0; k < N; k++) begin
         x_init[k]  = 32'(k) * 32'h1000;
         zk_init[k] = 32'(k) * 32'h1000;
         u_init[k]  = 32'h0;
      end
      lo = 32'h80000000;
      hi = 32'h7FFFFFFF;
      load_mem();
      run_sweep(dc, pe);
      check("inside_done_cycle", 32'(dc), 32'd49);
      check("inside_r_prim", r_prim, 32'h0);
      check("inside_r_dual", r_dual, 32'h0);
      for (int k = 0; k < N; k++) begin
         check($sformatf("inside_zk[%0d]", k), zk_mem[k], 32'(k) * 32'h1000);
         check($sformatf("inside_u[%0d]", k), u_mem[k], 32'h0);
      end

      // handshake: stray start at cycle 10, async reset at cycle 20
      for (int k = 0; k < N; k++) begin
         x_init[k]  = 32'(k) * 32'h1000;
         zk_init[k] = 32'h0000AAAA;
         u_init[k]  = 32'h0;
      end
      lo = 32'h0;
      hi = 32'h00004000;
      @(negedge clk);
      load_mem();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 10) start = 1'b1;
         if (c == 11) begin
            start = 1'b0;
            check("stray_start_addr", {27'h0, x_address0}, 32'd5);
         end
         if (c == 20) begin
            check("pre_reset_wb_addr", {27'h0, zk_address0}, 32'd9);
            reset = 1'b0;
            #1;
            check_idle_outputs("async_reset");
         end
      end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (k <= 8) begin
            ez = (k * 32'h1000 < 32'h4000) ? 32'(k) * 32'h1000 : 32'h4000;
            eu = 32'(k) * 32'h1000 - ez;
         end else begin
            ez = 32'h0000AAAA;
            eu = 32'h0;
         end
         check($sformatf("partial_zk[%0d]", k), zk_mem[k], ez);
         check($sformatf("partial_u[%0d]", k), u_mem[k], eu);
      end

      // fresh sweep after the reset completes normally
      load_mem();
      run_sweep(dc, pe);
      check("post_reset_done_cycle", 32'(dc), 32'd49);
      check("post_reset_protocol_errs", 32'(pe), 32'd0);
      check("post_reset_r_prim", r_prim, resid(32'h00013000));
      check("post_reset_r_dual", r_dual, resid(32'h0000AAAA));
      for (int k = 0; k < N; k++) begin
         ez = (k * 32'h1000 < 32'h4000) ? 32'(k) * 32'h1000 : 32'h4000;
         check($sformatf("post_reset_zk[%0d]", k), zk_mem[k], ez);
         check($sformatf("post_reset_u[%0d]", k), u_mem[k], 32'(k) * 32'h1000 - ez);
      end

      // outputs return to idle after done and residuals hold
      @(negedge clk);
      check("idle_after_done_busy", {31'h0, busy}, 32'h0);
      check("idle_after_done_r_prim", r_prim, resid(32'h00013000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mpc_qp_admm_z_update.md
# mpc_qp_admm_z_update

ADMM z/u update stage of the implicit-MPC QP solver. On `start` it sweeps all `AddressRange` entries, reading the relaxed primal vector x̃, the current slack z_k and the scaled dual u. For each entry it writes back z_{k+1} = clamp(x̃+u, lo, hi) and u_{k+1} = x̃+u−z_{k+1}. It is the direct consumer and producer of the zk slack RAM and the u RAM, and it reports max-norm primal and dual residuals to the iteration controller.

## Interface
Parameters:
- `DataWidth`, 32: word width; signed two's-complement Q16.16.
- `AddressWidth`, 5: RAM address width.
- `AddressRange`, 24: vector length N.

Ports:
- `clk`, in, 1: clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a sweep; sampled only in IDLE.
- `busy`, out, 1: high from the cycle after `start` until `done`.
- `done`, out, 1: one-cycle pulse when the sweep completes.
- `lo`, in, DataWidth: lower bound; must be held stable while `busy`.
- `hi`, in, DataWidth: upper bound; must be held stable while `busy`.
- `x_address0`, out, AddressWidth: x̃ RAM address.
- `x_ce0`, out, 1: x̃ RAM enable.
- `x_q0`, in, DataWidth: x̃ read data.
- `zk_address0`, out, AddressWidth: zk RAM address.
- `zk_ce0`, out, 1: zk RAM enable.
- `zk_we0`, out, 1: zk RAM write enable.
- `zk_d0`, out, DataWidth: zk write data.
- `zk_q0`, in, DataWidth: zk read data.
- `u_address0`, out, AddressWidth: u RAM address.
- `u_ce0`, out, 1: u RAM enable.
- `u_we0`, out, 1: u RAM write enable.
- `u_d0`, out, DataWidth: u write data.
- `u_q0`, in, DataWidth: u read data.
- `r_prim`, out, DataWidth: max over entries of |x̃ − z_{k+1}|.
- `r_dual`, out, DataWidth: max over entries of |z_{k+1} − z_k|.

## Operation
- RAM contract: single port, 1-cycle read latency, read-first; a write is issued with `ce0=1`, `we0=1`.
- FSM states: IDLE, RD, WB, DONE.
- IDLE: all enables low. On `start`:
  - clear index i, `r_prim` and `r_dual`;
  - go to RD.
- RD: drive address i on all three RAMs, `ce0=1`, `we0=0`. Go to WB.
- WB: `x_q0`, `zk_q0` and `u_q0` are valid. Compute:
  - v = sat32(x̃ + u), where the sum is taken at 33 bits and saturated to 0x7FFFFFFF or 0x80000000;
  - zn = min(max(v, lo), hi); if lo > hi, zn = hi;
  - un = sat32(v − zn).
- WB also:
  - writes zn to zk and un to u at address i (`ce0=1`, `we0=1`);
  - updates r_prim = max(r_prim, |sat32(x̃ − zn)|) and r_dual = max(r_dual, |sat32(zn − z_k)|);
  - |·| of 0x80000000 saturates to 0x7FFFFFFF.
- WB exit: if i = AddressRange−1, go to DONE; otherwise increment i and go to RD.
- DONE: pulse `done` and go to IDLE. `r_prim`/`r_dual` hold until the next `start`.
- The x̃ RAM is never written.
- `start` while not in IDLE is ignored.
- Reset mid-sweep:
  - FSM returns to IDLE and all outputs take their reset values;
  - RAM entries already written stay updated, the rest are untouched; no rollback.

## Timing
- Reset values: `busy`, `done`, all `ce0`/`we0` = 0; all addresses, `zk_d0`, `u_d0`, `r_prim`, `r_dual` = 0.
- 2 cycles per entry. With `start` sampled at cycle 0:
  - RD for entry i occurs at cycle 1+2i;
  - WB for entry i at cycle 2+2i;
  - `done` at cycle 2·AddressRange+1, which is 49 for N=24.
- `busy` is high from cycle 1 through cycle 2N+1 inclusive. The next `start` is accepted one cycle after `done`.
- Read and write never coincide on the same RAM in one cycle, so read-first ordering is not exercised.
- Residual registers update at the WB clock edge. Final values are valid in the cycle `done` is high.

## Configuration
- `MPC_ZUPD_RESID_EN` defined: residual datapath present as described.
- Undefined:
  - residual logic removed; `r_prim` and `r_dual` are tied to 0;
  - the z_k value read in WB is unused;
  - z/u results and timing are identical.

## Test plan
- Bounds, N=24, x̃=0x00010000 (1.0), u=0, z_k=0, lo=0xFFFF0000 (−1.0), hi=0x00008000 (0.5):
  - every zk entry = 0x00008000 and every u entry = 0x00008000;
  - `r_prim` = 0x00008000, `r_dual` = 0x00008000;
  - `done` at cycle 49.
- Inside bounds: x̃[i]=i·0x1000, u=0, z_k=x̃, lo=0x80000000, hi=0x7FFFFFFF:
  - zk[i]=x̃[i], u=0;
  - `r_prim`=0, `r_dual`=0.
- Saturation: x̃=0x7FFFFFFF, u=0x00000001, lo=0, hi=0x7FFFFFFF:
  - v saturates, so zn=0x7FFFFFFF and un=0;
  - `r_dual` = 0x7FFFFFFF when z_k=0.
- lo > hi: lo=0x00020000, hi=0x00010000, x̃=0 → zn=0x00010000 and un=0xFFFF0000.
- Handshake: a `start` pulse at cycle 10 of a sweep is ignored. Assert `reset` at cycle 20:
  - entries 0–8 are updated, entries 9+ are unchanged;
  - outputs go to 0 immediately, asynchronously;
  - a new `start` then completes normally.
- Back-to-back: a second `start` one cycle after `done` gives identical timing, and the residuals restart from 0.
